mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction-fetch stage and the data-memory stage. Accepts one request at a time from either side and drives it to a variable-latency memory with a req/ack handshake. Returns the response to the originating requester. Data accesses win by default; a starvation limit guarantees fetch progress. In-flight fetches can be squashed on a taken jump. Misaligned data accesses are trapped locally and never reach memory.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by instruction fetch and
// data memory. It handles one access at a time over a req/ack handshake and
// routes the response back to the side that issued it. Data wins by default.
// A starvation counter forces a fetch grant after STARVE_LIMIT data grants
// that were made while a fetch was waiting. Misaligned data accesses are
// answered locally with an error and never reach memory.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [2:0]        d_type_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_type_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR} state_t;

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [2:0] TYPE_WORD = 3'b010;

  state_t              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                kill_q, kill_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]          mem_type_q, mem_type_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_err_q, d_err_d;
  logic                if_gnt, d_gnt, d_misal, fetch_wins, d_done, d_trap;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0; bytes never trap.
  function automatic logic misaligned(input logic [2:0] typ, input logic [1:0] a);
    case (typ[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Grant decision and state transitions; grants only ever come out of IDLE.
  always_comb begin
    state_d    = state_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    d_misal    = misaligned(d_type_i, d_addr_i[1:0]);
    fetch_wins = if_req_i && (!d_req_i || starve_cnt_q == LIMIT);
    case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          if_gnt  = 1'b1;
          state_d = BUSY_IF;
        end else if (d_req_i) begin
          d_gnt   = 1'b1;
          state_d = d_misal ? ERR : BUSY_D;
        end
      end
      BUSY_IF, BUSY_D: if (mem_ack_i) state_d = IDLE;
      // ERR holds off grants for the cycle the error response is presented.
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the memory request, responses, kill flag and starvation count.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_type_d  = mem_type_q;
    if (if_gnt) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
      mem_type_d  = TYPE_WORD;
    end else if (d_gnt && !d_misal) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we_i;
      mem_addr_d  = d_addr_i;
      mem_wdata_d = d_wdata_i;
      mem_type_d  = d_type_i;
    end
    // BUSY states are exactly the cycles with mem_req high, so ack is gated by state.
    if ((state_q == BUSY_IF || state_q == BUSY_D) && mem_ack_i) mem_req_d = 1'b0;

    // A flush in the completing cycle itself also suppresses the response.
    if_rvalid_d = (state_q == BUSY_IF) && mem_ack_i && !(kill_q || if_flush_i);
    if_rdata_d  = if_rvalid_d ? mem_rdata_i : if_rdata_q;

    d_done     = (state_q == BUSY_D) && mem_ack_i;
    d_trap     = d_gnt && d_misal;
    d_rvalid_d = d_done || d_trap;
    d_err_d    = d_trap;
    d_rdata_d  = d_rdata_q;
    if (d_done)      d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
    else if (d_trap) d_rdata_d = '0;

    if (state_d == IDLE) kill_d = 1'b0;
    else                 kill_d = kill_q || (state_q == BUSY_IF && if_flush_i);

    starve_cnt_d = starve_cnt_q;
    if (if_gnt)                                             starve_cnt_d = '0;
    else if (d_gnt && if_req_i && starve_cnt_q != LIMIT)    starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_type_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_type_q   <= mem_type_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_type_o  = mem_type_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 2 time units after each
// rising edge, outputs are compared 1 unit later, well away from the edge.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [2:0]  d_type_i, mem_type_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .DATA_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_type_i(d_type_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_type_o(mem_type_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_type_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
    #3;
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_if_rvalid", 32'(if_rvalid_o), 0);
    chk("rst_d_rvalid", 32'(d_rvalid_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 0);
    tick(); tick();
    reset_i = 1'b0;

    // Lone fetch, ack two cycles after mem_req rises
    tick();
    if_req_i = 1; if_addr_i = 32'h100; #1;
    chk("lf_if_gnt", 32'(if_gnt_o), 1);
    chk("lf_d_gnt", 32'(d_gnt_o), 0);
    tick();
    if_req_i = 0; #1;
    chk("lf_mem_req", 32'(mem_req_o), 1);
    chk("lf_mem_addr", mem_addr_o, 32'h100);
    chk("lf_mem_type", 32'(mem_type_o), 2);
    chk("lf_mem_we", 32'(mem_we_o), 0);
    chk("lf_no_gnt_busy", 32'(if_gnt_o), 0);
    tick(); #1;
    chk("lf_mem_req_hold", 32'(mem_req_o), 1);
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'h00A00093; #1;
    chk("lf_rvalid_early", 32'(if_rvalid_o), 0);
    tick();
    mem_ack_i = 0; #1;
    chk("lf_if_rvalid", 32'(if_rvalid_o), 1);
    chk("lf_if_rdata", if_rdata_o, 32'h00A00093);
    chk("lf_mem_req_clr", 32'(mem_req_o), 0);
    tick(); #1;
    chk("lf_rvalid_pulse", 32'(if_rvalid_o), 0);

    // Contention: data first, then fetch in the next IDLE cycle
    tick();
    if_req_i = 1; if_addr_i = 32'h104;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200; d_type_i = 3'b010; #1;
    chk("ct_d_gnt", 32'(d_gnt_o), 1);
    chk("ct_if_gnt", 32'(if_gnt_o), 0);
    tick();
    d_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h11112222; #1;
    chk("ct_mem_addr_d", mem_addr_o, 32'h200);
    chk("ct_if_gnt_busy", 32'(if_gnt_o), 0);
    tick();
    mem_ack_i = 0; #1;
    chk("ct_d_rvalid", 32'(d_rvalid_o), 1);
    chk("ct_d_rdata", d_rdata_o, 32'h11112222);
    chk("ct_if_rvalid_lo", 32'(if_rvalid_o), 0);
    chk("ct_if_gnt", 32'(if_gnt_o), 1);
    tick();
    if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h33334444; #1;
    chk("ct_mem_addr_if", mem_addr_o, 32'h104);
    chk("ct_d_rvalid_lo", 32'(d_rvalid_o), 0);
    tick();
    mem_ack_i = 0; #1;
    chk("ct_if_rvalid", 32'(if_rvalid_o), 1);
    chk("ct_if_rdata", if_rdata_o, 32'h33334444);

    // Starvation: four data grants, one forced fetch grant, then data again
    tick();
    if_req_i = 1; if_addr_i = 32'h400;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200; d_type_i = 3'b010;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick();
        mem_ack_i = 0;
      end
      #1;
      chk($sformatf("sv_if_gnt_%0d", i), 32'(if_gnt_o), 32'(i == 4));
      chk($sformatf("sv_d_gnt_%0d", i), 32'(d_gnt_o), 32'(i != 4));
      chk($sformatf("sv_cnt_%0d", i), 32'(dut.starve_cnt_q), (i <= 4) ? 32'(i) : 32'd0);
      tick();
      mem_ack_i = 1; mem_rdata_i = 32'h1000 + 32'(i);
    end
    tick();
    mem_ack_i = 0; if_req_i = 0; d_req_i = 0; #1;
    chk("sv_last_d_rvalid", 32'(d_rvalid_o), 1);
    chk("sv_last_d_rdata", d_rdata_o, 32'h1005);

    // Flush: killed fetch gives no response; next fetch (flush in IDLE) is normal
    tick();
    if_req_i = 1; if_addr_i = 32'h300; #1;
    chk("fl_if_gnt", 32'(if_gnt_o), 1);
    tick();
    if_req_i = 0; if_flush_i = 1;
    tick();
    if_flush_i = 0;
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    tick();
    mem_ack_i = 0; #1;
    chk("fl_killed_rvalid", 32'(if_rvalid_o), 0);
    chk("fl_mem_req_clr", 32'(mem_req_o), 0);
    if_req_i = 1; if_addr_i = 32'h308; if_flush_i = 1; #1;
    chk("fl_regrant", 32'(if_gnt_o), 1);
    tick();
    if_req_i = 0; if_flush_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h55556666; #1;
    chk("fl_mem_addr", mem_addr_o, 32'h308);
    tick();
    mem_ack_i = 0; #1;
    chk("fl_if_rvalid", 32'(if_rvalid_o), 1);
    chk("fl_if_rdata", if_rdata_o, 32'h55556666);

    // Stray ack while idle must be ignored
    tick();
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0; #1;
    chk("ig_d_rvalid", 32'(d_rvalid_o), 0);
    chk("ig_if_rvalid", 32'(if_rvalid_o), 0);

    // Misaligned word load
    tick();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h202; d_type_i = 3'b010; #1;
    chk("mw_d_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; #1;
    chk("mw_d_rvalid", 32'(d_rvalid_o), 1);
    chk("mw_d_err", 32'(d_err_o), 1);
    chk("mw_d_rdata", d_rdata_o, 0);
    chk("mw_mem_req", 32'(mem_req_o), 0);
    tick(); #1;
    chk("mw_d_rvalid_pulse", 32'(d_rvalid_o), 0);
    chk("mw_d_err_pulse", 32'(d_err_o), 0);
    chk("mw_mem_req_after", 32'(mem_req_o), 0);

    // Misaligned half load
    tick();
    d_req_i = 1; d_addr_i = 32'h201; d_type_i = 3'b001; #1;
    chk("mh_d_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; #1;
    chk("mh_d_err", 32'(d_err_o), 1);
    chk("mh_mem_req", 32'(mem_req_o), 0);

    // Aligned half load at 0x202 reaches memory
    tick(); tick();
    d_req_i = 1; d_addr_i = 32'h202; d_type_i = 3'b001; #1;
    chk("ah_d_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h0000BEEF; #1;
    chk("ah_mem_req", 32'(mem_req_o), 1);
    chk("ah_mem_type", 32'(mem_type_o), 1);
    tick();
    mem_ack_i = 0; #1;
    chk("ah_d_rvalid", 32'(d_rvalid_o), 1);
    chk("ah_d_err", 32'(d_err_o), 0);
    chk("ah_d_rdata", d_rdata_o, 32'h0000BEEF);

    // Word store
    tick();
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h204; d_wdata_i = 32'hDEADBEEF; d_type_i = 3'b010; #1;
    chk("st_d_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; d_we_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hFFFFFFFF; #1;
    chk("st_mem_we", 32'(mem_we_o), 1);
    chk("st_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("st_mem_addr", mem_addr_o, 32'h204);
    tick();
    mem_ack_i = 0; #1;
    chk("st_d_rvalid", 32'(d_rvalid_o), 1);
    chk("st_d_rdata", d_rdata_o, 0);
    chk("st_d_err", 32'(d_err_o), 0);

    // Reset in BUSY_D drops everything at once, no response afterwards
    tick();
    d_req_i = 1; d_addr_i = 32'h208; d_type_i = 3'b010; #1;
    chk("rb_d_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; #1;
    chk("rb_mem_req_pre", 32'(mem_req_o), 1);
    #1 reset_i = 1'b1;
    #1;
    chk("rb_mem_req_async", 32'(mem_req_o), 0);
    chk("rb_mem_addr", mem_addr_o, 0);
    chk("rb_d_rvalid", 32'(d_rvalid_o), 0);
    tick();
    reset_i = 1'b0;
    tick(); #1;
    chk("rb_after_mem_req", 32'(mem_req_o), 0);
    chk("rb_after_d_rvalid", 32'(d_rvalid_o), 0);
    d_req_i = 1; #1;
    chk("rb_idle_gnt", 32'(d_gnt_o), 1);
    tick();
    d_req_i = 0; #1;
    chk("rb_no_stale_rvalid", 32'(d_rvalid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
